ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter, the send direction of the keyboard link. It lets the core send command bytes to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It drives the PS/2 clock and data lines as open-drain pull-downs, sharing the same pins as the keyboard receiver. Frame format: inhibit, request-to-send, start bit, 8 data bits LSB first, odd parity, stop bit, then the device ACK.

---
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, device ACK.
// Define PS2_TX_RETRY_EN to resend automatically after a NACK or timeout (up to MAX_RETRY times).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall, timed_out;
    logic [7:0]    data_q, data_nxt;
    logic          parity_q, parity_nxt;
    logic          nack_q, nack_nxt;
    logic [IW-1:0] inh_cnt, inh_nxt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic [3:0]    bit_idx, bit_nxt;
    logic [7:0]    retry_cnt, retry_nxt;
    logic          clk_oe_nxt, data_oe_nxt, done_nxt, ack_err_nxt, to_err_nxt;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign timed_out = (state inside {SEND, ACK, WAIT_IDLE}) &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        parity_nxt  = parity_q;
        nack_nxt    = nack_q;
        inh_nxt     = inh_cnt;
        to_nxt      = to_cnt;
        bit_nxt     = bit_idx;
        retry_nxt   = retry_cnt;
        clk_oe_nxt  = ps2_clk_oe;
        data_oe_nxt = ps2_data_oe;
        done_nxt    = 1'b0;
        ack_err_nxt = 1'b0;
        to_err_nxt  = 1'b0;
        case (state)
            IDLE: if (tx_valid) begin
                data_nxt    = tx_data;
                parity_nxt  = ~^tx_data;
                retry_nxt   = '0;
                inh_nxt     = '0;
                clk_oe_nxt  = 1'b1;
                data_oe_nxt = 1'b0;
                state_nxt   = INHIBIT;
            end
            INHIBIT: begin
                inh_nxt = inh_cnt + 1'b1;
                // Start bit goes out during the last inhibit cycle so it is stable at release.
                if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) data_oe_nxt = 1'b1;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    inh_nxt    = '0;
                    clk_oe_nxt = 1'b0;
                    bit_nxt    = '0;
                    to_nxt     = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                to_nxt = to_cnt + 1'b1;
                if (fall) begin
                    bit_nxt = bit_idx + 1'b1;
                    if (bit_idx < 4'd8)       data_oe_nxt = ~data_q[bit_idx[2:0]];
                    else if (bit_idx == 4'd8) data_oe_nxt = ~parity_q;
                    else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end
                end
            end
            ACK: begin
                to_nxt = to_cnt + 1'b1;
                if (fall) begin
                    nack_nxt  = data_sync[1];
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                to_nxt = to_cnt + 1'b1;
                if (clk_sync[1] && data_sync[1]) begin
                    done_nxt    = 1'b1;
                    ack_err_nxt = nack_q;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Timeout overrides any frame progress made in the same cycle.
        if (timed_out) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b0;
            ack_err_nxt = 1'b0;
            to_err_nxt  = 1'b1;
            state_nxt   = IDLE;
        end

        if (RETRY_EN && (to_err_nxt || (done_nxt && ack_err_nxt)) &&
            retry_cnt < 8'(MAX_RETRY)) begin
            retry_nxt   = retry_cnt + 1'b1;
            inh_nxt     = '0;
            clk_oe_nxt  = 1'b1;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b0;
            ack_err_nxt = 1'b0;
            to_err_nxt  = 1'b0;
            state_nxt   = INHIBIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clk_sync    <= '1;
            data_sync   <= '1;
            data_q      <= '0;
            parity_q    <= 1'b0;
            nack_q      <= 1'b0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_idx     <= '0;
            retry_cnt   <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_sync    <= {clk_sync[1:0], ps2_clk};
            data_sync   <= {data_sync[0], ps2_data};
            data_q      <= data_nxt;
            parity_q    <= parity_nxt;
            nack_q      <= nack_nxt;
            inh_cnt     <= inh_nxt;
            to_cnt      <= to_nxt;
            bit_idx     <= bit_nxt;
            retry_cnt   <= retry_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            done        <= done_nxt;
            ack_err     <= ack_err_nxt;
            timeout_err <= to_err_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, behavioural PS/2 device, frame-level scoreboard.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 4000;
    localparam int HALF = 50;
`ifdef PS2_TX_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    logic clk = 1'b0, rst;
    logic ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic tx_valid, tx_ready, busy, done, ack_err, timeout_err;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .ack_err(ack_err), .timeout_err(timeout_err));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2) == 0;
    endfunction

    // Line monitor: inhibit phases, start bit, done/timeout pulses.
    int cyc = 0, run = 0, phases = 0, inh_bad = 0, start_bad = 0;
    int done_cnt = 0, to_cnt = 0, send_entry = 0, to_delay = 0;
    logic prev_coe = 1'b0, prev_doe = 1'b0, last_ack_err = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_coe <= ps2_clk_oe;
        prev_doe <= ps2_data_oe;
        if (ps2_clk_oe) run <= prev_coe ? run + 1 : 1;
        if (ps2_clk_oe && !prev_coe) phases <= phases + 1;
        if (!ps2_clk_oe && prev_coe) begin
            if (run != INH) inh_bad <= inh_bad + 1;
            if (!prev_doe) start_bad <= start_bad + 1;
            send_entry <= cyc + 1;
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            last_ack_err <= ack_err;
        end
        if (timeout_err) begin
            to_cnt   <= to_cnt + 1;
            to_delay <= cyc + 1 - send_entry;
        end
    end

    // Device model: clocks 11 pulses at 1/100 of clk, samples on rising edges, ACKs or NACKs.
    logic [7:0] dev_bytes[$];
    logic       dev_par[$];
    logic       dev_stop[$];
    logic       dev_silent = 1'b0, dev_busy = 1'b0;
    int         dev_nack_left = 0, dev_pulse = 0;

    initial begin : device
        logic [7:0] b;
        logic par, stop, nk;
        forever begin
            @(negedge ps2_clk_oe);
            #1;
            if (ps2_data_line !== 1'b0 || dev_silent) continue;
            dev_busy  = 1'b1;
            dev_pulse = 0;
            nk = (dev_nack_left > 0);
            if (nk) dev_nack_left--;
            b = '0; par = 1'b0; stop = 1'b0;
            repeat (HALF) @(posedge clk);
            for (int k = 1; k <= 11; k++) begin
                dev_clk_low = 1'b1;
                dev_pulse   = k;
                repeat (HALF) @(posedge clk);
                if (k <= 8)       b[k-1] = ps2_data_line;
                else if (k == 9)  par    = ps2_data_line;
                else if (k == 10) stop   = ps2_data_line;
                dev_clk_low = 1'b0;
                if (k == 10 && !nk) dev_data_low = 1'b1;
                if (k == 11) dev_data_low = 1'b0;
                if (k < 11) repeat (HALF) @(posedge clk);
            end
            dev_bytes.push_back(b);
            dev_par.push_back(par);
            dev_stop.push_back(stop);
            dev_busy = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || dev_busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy | dev_busy}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, input int p);
        int n = 0;
        while (dev_pulse != p && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pulse"}, dev_pulse, p);
    endtask

    // One command, device NACKs the first `nack` frames; poke injects a mid-frame tx_valid.
    task automatic txn(input string tag, input logic [7:0] b, input int nack, input bit poke);
        int ph0, ib0, sb0, dc0, tc0, frames;
        logic exp_err;
        ph0 = phases; ib0 = inh_bad; sb0 = start_bad; dc0 = done_cnt; tc0 = to_cnt;
        frames  = (nack > RETRIES) ? RETRIES + 1 : nack + 1;
        exp_err = (nack > RETRIES);
        dev_bytes.delete(); dev_par.delete(); dev_stop.delete();
        dev_nack_left = nack;
        send(b);
        if (poke) begin
            wait_pulse(tag, 4);
            @(negedge clk);
            chk({tag, "_ready_busy"}, {31'd0, tx_ready}, 32'd0);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        wait_idle(tag);
        chk({tag, "_phases"}, phases - ph0, frames);
        chk({tag, "_inh_len"}, inh_bad - ib0, 0);
        chk({tag, "_start"}, start_bad - sb0, 0);
        chk({tag, "_done"}, done_cnt - dc0, 1);
        chk({tag, "_ack_err"}, {31'd0, last_ack_err}, {31'd0, exp_err});
        chk({tag, "_tmo"}, to_cnt - tc0, 0);
        chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({tag, "_frames"}, dev_bytes.size(), frames);
        foreach (dev_bytes[i]) begin
            chk({tag, "_byte"}, {24'd0, dev_bytes[i]}, {24'd0, b});
            chk({tag, "_par"}, {31'd0, dev_par[i]}, {31'd0, odd_par(b)});
            chk({tag, "_stop"}, {31'd0, dev_stop[i]}, 32'd1);
        end
    endtask

    initial begin
        int ph0, dc0, tc0;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {29'd0, done, ack_err, timeout_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        txn("ed_ack", 8'hED, 0, 1'b0);
        txn("ed_nack", 8'hED, 1, 1'b0);
        txn("nack2", 8'hA5, 2, 1'b0);
        txn("ff_poke", 8'hFF, 0, 1'b1);
        repeat (200) @(negedge clk);
        chk("no_queue", {31'd0, busy}, 32'd0);

        // Silent device: timeout after TMO cycles in SEND, no done.
        ph0 = phases; dc0 = done_cnt; tc0 = to_cnt;
        dev_silent = 1'b1;
        send(8'hF0);
        wait_idle("tmo");
        chk("tmo_pulse", to_cnt - tc0, 1);
        chk("tmo_delay", to_delay, TMO);
        chk("tmo_done", done_cnt - dc0, 0);
        chk("tmo_phases", phases - ph0, RETRIES + 1);
        chk("tmo_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        dev_silent = 1'b0;

        // Reset while inhibiting.
        send(8'h3C);
        repeat (5) @(negedge clk);
        chk("inh_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_inh_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Reset during bit 4 of 0xF4, then a clean resend.
        dev_nack_left = 0;
        send(8'hF4);
        wait_pulse("rst_mid", 5);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("rst_mid_idle", {30'd0, tx_ready, busy}, 32'd2);
        @(negedge clk); rst = 1'b0;
        wait_idle("rst_mid");
        txn("f4_after_rst", 8'hF4, 0, 1'b0);

        for (int i = 0; i < 5; i++)
            txn("rnd", 8'($urandom), int'($urandom_range(0, 3)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
